// File: rtl/clock_key_ctrl.sv
// -----------------------------------------------------------------------------
// clock_key_ctrl
// Front-panel sequencer for the multi-mode clock. It turns three raw
// push-buttons into the display mode bus, the increment strobes, the stopwatch
// run level and the edit-field blink phase.
//
// Ports
//   Clk      in   system clock
//   CR       in   asynchronous active-high clear
//   KeyMode  in   raw mode button, 1 = pressed
//   KeySet   in   raw set button, 1 = pressed
//   KeyUp    in   raw increment button, 1 = pressed
//   Mode     out  one-hot display/function mode (6'b000000 = time)
//   EditH    out  high-field (hour) edit active
//   EditL    out  low-field (minute) edit active
//   AddH     out  one-cycle hour/high increment strobe
//   AddL     out  one-cycle minute/low increment strobe, also stopwatch clear
//   WatchSt  out  stopwatch run level
//   Blink    out  blink phase for the field being edited
// -----------------------------------------------------------------------------
module clock_key_ctrl #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned REP_DELAY  = 25000000,
  parameter int unsigned REP_PERIOD = 10000000,
  parameter int unsigned TIMEOUT    = 500000000,
  parameter int unsigned BLINK_HALF = 12500000
) (
  input  logic       Clk,
  input  logic       CR,
  input  logic       KeyMode,
  input  logic       KeySet,
  input  logic       KeyUp,
  output logic [5:0] Mode,
  output logic       EditH,
  output logic       EditL,
  output logic       AddH,
  output logic       AddL,
  output logic       WatchSt,
  output logic       Blink
);

  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned BLK_W   = $clog2(BLINK_HALF + 1);

  localparam logic [5:0] MODE_TIME  = 6'b000000;
  localparam logic [5:0] MODE_ALARM = 6'b000010;
  localparam logic [5:0] MODE_WATCH = 6'b001000;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_EDIT_H = 2'd1,
    ST_EDIT_L = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Key conditioning: bit 0 = KeyMode, bit 1 = KeySet, bit 2 = KeyUp.
  // ---------------------------------------------------------------------------
  logic [2:0] key_raw;
  logic [2:0] key_lvl;    // debounced levels
  logic [2:0] key_press;  // one-cycle pulse on debounced 0->1

  assign key_raw = {KeyUp, KeySet, KeyMode};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic             sync1_q;
      logic             sync2_q;
      logic             deb_q;
      logic             deb_dly_q;
      logic [DEB_W-1:0] deb_cnt_q;
      logic             deb_d;
      logic [DEB_W-1:0] deb_cnt_d;

      // The counter only advances while the synchronized level disagrees with
      // the accepted one, so any glitch shorter than DEB_CYCLES dies out.
      always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
          if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
            deb_d     = ~deb_q;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge Clk or posedge CR) begin
        if (CR) begin
          sync1_q   <= 1'b0;
          sync2_q   <= 1'b0;
          deb_q     <= 1'b0;
          deb_dly_q <= 1'b0;
          deb_cnt_q <= '0;
        end else begin
          sync1_q   <= key_raw[gi];
          sync2_q   <= sync1_q;
          deb_q     <= deb_d;
          deb_dly_q <= deb_q;
          deb_cnt_q <= deb_cnt_d;
        end
      end

      assign key_lvl[gi]   = deb_q;
      assign key_press[gi] = deb_q & ~deb_dly_q;
    end
  endgenerate

  // Only the highest-priority press in a cycle is served.
  logic ev_mode;
  logic ev_set;
  logic ev_up;
  logic up_held;

  assign ev_mode = key_press[0];
  assign ev_set  = key_press[1] & ~key_press[0];
  assign ev_up   = key_press[2] & ~key_press[1] & ~key_press[0];
  assign up_held = key_lvl[2];

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic [5:0]        mode_q,      mode_d;
  logic              watch_q,     watch_d;
  logic              add_h_q,     add_h_d;
  logic              add_l_q,     add_l_d;
  logic              rep_act_q,   rep_act_d;
  logic              rep_phase_q, rep_phase_d;  // 0: initial delay, 1: periodic
  logic [REP_W-1:0]  rep_cnt_q,   rep_cnt_d;
  logic [IDLE_W-1:0] idle_q,      idle_d;
  logic              blink_q,     blink_d;
  logic [BLK_W-1:0]  blk_cnt_q,   blk_cnt_d;

  logic              rep_hit;

  assign rep_hit = rep_phase_q ? (rep_cnt_q == REP_W'(REP_PERIOD - 1))
                               : (rep_cnt_q == REP_W'(REP_DELAY - 1));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    watch_d     = watch_q;
    add_h_d     = 1'b0;
    add_l_d     = 1'b0;
    rep_act_d   = 1'b0;
    rep_phase_d = 1'b0;
    rep_cnt_d   = '0;
    idle_d      = '0;
    blink_d     = 1'b0;
    blk_cnt_d   = '0;

    case (state_q)
      ST_NORMAL: begin
        if (ev_mode) begin
          // Shifting the top bit out wraps the walk back to the time mode.
          mode_d = (mode_q == MODE_TIME) ? 6'b000001 : {mode_q[4:0], 1'b0};
        end else if (ev_set) begin
          if (mode_q == MODE_TIME || mode_q == MODE_ALARM) begin
            state_d = ST_EDIT_H;
          end else if (mode_q == MODE_WATCH) begin
            watch_d = ~watch_q;
          end
        end else if (ev_up) begin
          // Stopwatch clear is only allowed while it is stopped.
          if (mode_q == MODE_WATCH && !watch_q) begin
            add_l_d = 1'b1;
          end
        end
      end

      ST_EDIT_H, ST_EDIT_L: begin
        if (ev_mode) begin
          state_d = ST_NORMAL;
        end else if (ev_set) begin
          state_d = (state_q == ST_EDIT_H) ? ST_EDIT_L : ST_NORMAL;
        end else if (ev_up) begin
          add_h_d   = (state_q == ST_EDIT_H);
          add_l_d   = (state_q == ST_EDIT_L);
          rep_act_d = 1'b1;
        end else if (rep_act_q && up_held) begin
          rep_act_d = 1'b1;
          if (rep_hit) begin
            add_h_d     = (state_q == ST_EDIT_H);
            add_l_d     = (state_q == ST_EDIT_L);
            rep_phase_d = 1'b1;
          end else begin
            rep_phase_d = rep_phase_q;
            rep_cnt_d   = rep_cnt_q + 1'b1;
          end
        end

        // Idle timeout: any press, or a held KeyUp, counts as activity.
        if (!(|key_press) && !up_held) begin
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d = ST_NORMAL;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_NORMAL;
      end
    endcase

    // Any state change kills a running repeat.
    if (state_d != state_q) begin
      rep_act_d   = 1'b0;
      rep_phase_d = 1'b0;
      rep_cnt_d   = '0;
      idle_d      = '0;
    end

    // Blink phase restarts on every edit entry and is frozen on while KeyUp
    // is held, so the field stays visible while it is being stepped.
    if (state_d != ST_NORMAL) begin
      if (state_d != state_q || up_held) begin
        blink_d   = 1'b1;
        blk_cnt_d = '0;
      end else if (blk_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
        blink_d   = ~blink_q;
        blk_cnt_d = '0;
      end else begin
        blink_d   = blink_q;
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge CR) begin
    if (CR) begin
      state_q     <= ST_NORMAL;
      mode_q      <= MODE_TIME;
      watch_q     <= 1'b0;
      add_h_q     <= 1'b0;
      add_l_q     <= 1'b0;
      rep_act_q   <= 1'b0;
      rep_phase_q <= 1'b0;
      rep_cnt_q   <= '0;
      idle_q      <= '0;
      blink_q     <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      watch_q     <= watch_d;
      add_h_q     <= add_h_d;
      add_l_q     <= add_l_d;
      rep_act_q   <= rep_act_d;
      rep_phase_q <= rep_phase_d;
      rep_cnt_q   <= rep_cnt_d;
      idle_q      <= idle_d;
      blink_q     <= blink_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign Mode    = mode_q;
  assign EditH   = (state_q == ST_EDIT_H);
  assign EditL   = (state_q == ST_EDIT_L);
  assign AddH    = add_h_q;
  assign AddL    = add_l_q;
  assign WatchSt = watch_q;
  assign Blink   = blink_q;

endmodule

// File: tb/tb_clock_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_key_ctrl
// Directed bench for clock_key_ctrl with short timing parameters. Expected
// values are hand-derived from the key sequences below.
// -----------------------------------------------------------------------------
module tb_clock_key_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 20;
  localparam int unsigned RP  = 5;
  localparam int unsigned TO  = 100;
  localparam int unsigned BH  = 8;

  logic       Clk = 1'b0;
  logic       CR = 1'b1;
  logic       KeyMode = 1'b0;
  logic       KeySet = 1'b0;
  logic       KeyUp = 1'b0;
  logic [5:0] Mode;
  logic       EditH, EditL, AddH, AddL, WatchSt, Blink;

  int checks = 0;
  int errors = 0;
  int addh_cnt = 0;
  int addl_cnt = 0;
  int both_cnt = 0;

  clock_key_ctrl #(
    .DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP), .TIMEOUT(TO), .BLINK_HALF(BH)
  ) dut (
    .Clk(Clk), .CR(CR), .KeyMode(KeyMode), .KeySet(KeySet), .KeyUp(KeyUp),
    .Mode(Mode), .EditH(EditH), .EditL(EditL), .AddH(AddH), .AddL(AddL),
    .WatchSt(WatchSt), .Blink(Blink)
  );

  always #5 Clk = ~Clk;

  // Strobe monitor: one count per cycle a strobe is high.
  always @(negedge Clk) begin
    if (AddH) addh_cnt <= addh_cnt + 1;
    if (AddL) addl_cnt <= addl_cnt + 1;
    if (AddH && AddL) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  task automatic press(input bit m, input bit s, input bit u, input int hold);
    KeyMode = m;
    KeySet  = s;
    KeyUp   = u;
    cyc(hold);
    KeyMode = 1'b0;
    KeySet  = 1'b0;
    KeyUp   = 1'b0;
    cyc(10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_mode[7];
    int h0, l0, blink_low, tog;
    logic prev;
    exp_mode = '{1, 2, 4, 8, 16, 32, 0};

    // Reset state
    cyc(3);
    check("rst_mode", Mode, 0);
    check("rst_outs", {EditH, EditL, AddH, AddL, WatchSt, Blink}, 0);
    CR = 1'b0;
    cyc(3);

    // Mode walk and glitch rejection
    for (int i = 0; i < 7; i++) begin
      press(1, 0, 0, 10);
      check($sformatf("walk_%0d", i), Mode, exp_mode[i]);
    end
    KeyMode = 1'b1;
    cyc(2);
    KeyMode = 1'b0;
    cyc(10);
    check("glitch_mode", Mode, 0);

    // EDIT_H entry, held KeyUp with auto-repeat, blink behaviour
    KeySet = 1'b1;
    cyc(10);
    KeySet = 1'b0;
    check("edh_entry", EditH, 1);
    check("edh_blink_entry", Blink, 1);
    h0 = addh_cnt;
    l0 = addl_cnt;
    blink_low = 0;
    KeyUp = 1'b1;
    cyc(8);
    for (int i = 0; i < 25; i++) begin
      cyc(1);
      if (!Blink) blink_low++;
    end
    KeyUp = 1'b0;
    cyc(10);
    check("rep_blink_low", blink_low, 0);
    check("rep_addh", addh_cnt - h0, 4);
    check("rep_addl", addl_cnt - l0, 0);
    prev = Blink;
    tog = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (Blink != prev) tog++;
      prev = Blink;
    end
    check("blink_toggles", tog, 5);
    check("edh_still", EditH, 1);
    press(1, 0, 0, 10);
    check("edh_exit_edit", EditH, 0);
    check("edh_exit_mode", Mode, 0);
    check("edh_exit_blink", Blink, 0);

    // Alarm mode: EDIT_H -> EDIT_L -> AddL -> NORMAL
    press(1, 0, 0, 10);
    press(1, 0, 0, 10);
    check("alm_mode", Mode, 2);
    press(0, 1, 0, 10);
    check("alm_edh", {EditH, EditL}, 2);
    press(0, 1, 0, 10);
    check("alm_edl", {EditH, EditL}, 1);
    h0 = addh_cnt;
    l0 = addl_cnt;
    press(0, 0, 1, 10);
    check("alm_addl", addl_cnt - l0, 1);
    check("alm_addh", addh_cnt - h0, 0);
    press(0, 1, 0, 10);
    check("alm_exit", {EditH, EditL}, 0);
    check("alm_mode_kept", Mode, 2);

    // Timeout from EDIT_L in time mode
    for (int i = 0; i < 5; i++) press(1, 0, 0, 10);
    check("to_mode", Mode, 0);
    press(0, 1, 0, 10);
    press(0, 1, 0, 10);
    check("to_edl", EditL, 1);
    cyc(70);
    check("to_before", EditL, 1);
    cyc(30);
    check("to_after", EditL, 0);
    check("to_blink", Blink, 0);
    check("to_mode_kept", Mode, 0);

    // Stopwatch mode
    for (int i = 0; i < 4; i++) press(1, 0, 0, 10);
    check("sw_mode", Mode, 8);
    press(0, 1, 0, 10);
    check("sw_run", WatchSt, 1);
    l0 = addl_cnt;
    press(0, 0, 1, 10);
    check("sw_up_running", addl_cnt - l0, 0);
    press(0, 1, 0, 10);
    check("sw_stop", WatchSt, 0);
    l0 = addl_cnt;
    press(0, 0, 1, 10);
    check("sw_clear", addl_cnt - l0, 1);
    press(0, 1, 0, 10);
    press(1, 0, 0, 10);
    check("sw_leave_mode", Mode, 16);
    check("sw_leave_run", WatchSt, 1);
    press(1, 0, 0, 10);
    press(1, 0, 0, 10);
    check("sw_back_time", Mode, 0);

    // Simultaneous KeyMode + KeySet: mode wins
    press(1, 1, 0, 10);
    check("prio_mode", Mode, 1);
    check("prio_edit", {EditH, EditL}, 0);

    // CR in the middle of auto-repeat
    press(1, 0, 0, 10);
    press(0, 1, 0, 10);
    check("cr_edh", EditH, 1);
    KeyUp = 1'b1;
    cyc(30);
    #2;
    CR = 1'b1;
    #1;
    check("cr_mode", Mode, 0);
    check("cr_outs", {EditH, EditL, AddH, AddL, WatchSt, Blink}, 0);
    @(negedge Clk);
    CR = 1'b0;
    h0 = addh_cnt;
    cyc(5);
    KeyUp = 1'b0;
    cyc(12);
    check("cr_no_strobe", addh_cnt - h0, 0);
    check("cr_normal", {EditH, EditL}, 0);

    check("strobe_overlap", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
